// File: rtl/fpu_share_pkg.sv
// rtl/fpu_share_pkg.sv - shared state encoding and index-width helper for the FPU share arbiter
package fpu_share_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fpu_share_state_e;

  // ceil(log2(n)); 1 for n<=2 so index vectors never collapse to zero width
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fpu_share_rr_sel.sv
// rtl/fpu_share_rr_sel.sv - round-robin pick of the first eligible requester at or after ptr
module fpu_share_rr_sel
  import fpu_share_pkg::*;
#(
  parameter int NB_REQ = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NB_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the far end back toward ptr so the closest candidate wins last
  always_comb begin
    winner = '0;
    cand   = '0;
    valid  = |eligible;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (eligible[cand]) winner = cand;
    end
  end

endmodule

// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - shares one FPU among NB_REQ requesters with round-robin and lock-on-stall
// Optional conflict counter perf_conflicts_o enabled by FPU_SHARE_PERF_EN.
module fpu_share_arbiter
  import fpu_share_pkg::*;
#(
  parameter int NB_REQ          = 4,
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int MAX_OUTST       = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [NB_REQ-1:0]                                  req_i,
  output logic [NB_REQ-1:0]                                  gnt_o,
  input  logic [NB_REQ-1:0][ID_WIDTH-1:0]                    ID_i,
  input  logic [NB_REQ-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0]     operands_i,
  input  logic [NB_REQ-1:0][OPCODE_WIDTH-1:0]                op_i,
  input  logic [NB_REQ-1:0][FLAGS_IN_WIDTH-1:0]              flags_i,
  output logic [NB_REQ-1:0]                                  rvalid_o,
  output logic [DATA_WIDTH-1:0]                              rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]                         rflags_o,
  output logic [ID_WIDTH-1:0]                                rID_o,
  output logic                                               fpu_req_o,
  input  logic                                               fpu_gnt_i,
  output logic [ID_WIDTH+clog2(NB_REQ)-1:0]                  fpu_ID_o,
  output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]                 fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]                            fpu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]                          fpu_flags_o,
  input  logic                                               fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                              fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]                         fpu_rflags_i,
`ifdef FPU_SHARE_PERF_EN
  input  logic [ID_WIDTH+clog2(NB_REQ)-1:0]                  fpu_rID_i,
  output logic [31:0]                                        perf_conflicts_o
`else
  input  logic [ID_WIDTH+clog2(NB_REQ)-1:0]                  fpu_rID_i
`endif
);

  localparam int IDX_W = clog2(NB_REQ);
  localparam int OW    = clog2(MAX_OUTST + 1);
  localparam logic [0:0]    ST_IDLE   = IDLE;
  localparam logic [0:0]    ST_LOCKED = LOCKED;
  localparam logic [OW-1:0] MAX_CNT   = OW'(MAX_OUTST);

  logic [0:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  lock_idx;
  logic [IDX_W-1:0]  rr_win;
  logic [IDX_W-1:0]  sel;
  logic [IDX_W-1:0]  rsp_idx;
  logic              rr_valid;
  logic              grant;
  logic              rsp_ok;
  logic [NB_REQ-1:0] eligible;
  logic [NB_REQ-1:0] dec_vec;
  logic [OW-1:0]     outst [NB_REQ];

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      eligible[k] = req_i[k] && (outst[k] < MAX_CNT);
    end
  end

  fpu_share_rr_sel #(
    .NB_REQ (NB_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_sel (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .winner   (rr_win),
    .valid    (rr_valid)
  );

  // A stalled winner stays selected until the FPU takes it, whatever the other requesters do
  assign sel       = (state == ST_LOCKED) ? lock_idx : rr_win;
  assign fpu_req_o = (state == ST_LOCKED) || rr_valid;
  assign grant     = fpu_req_o && fpu_gnt_i;
  assign gnt_o     = grant ? (NB_REQ'(1) << sel) : '0;

  assign fpu_ID_o       = {sel, ID_i[sel]};
  assign fpu_operands_o = operands_i[sel];
  assign fpu_op_o       = op_i[sel];
  assign fpu_flags_o    = flags_i[sel];

  // Results for a requester with nothing in flight are stale (e.g. issued before reset)
  assign rsp_idx = fpu_rID_i[ID_WIDTH +: IDX_W];
  assign rsp_ok  = fpu_rvalid_i && (outst[rsp_idx] != '0);
  assign dec_vec = rsp_ok ? (NB_REQ'(1) << rsp_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      if (grant) rr_ptr <= sel + IDX_W'(1);
      case (state)
        ST_IDLE: begin
          if (rr_valid && !fpu_gnt_i) begin
            state    <= ST_LOCKED;
            lock_idx <= rr_win;
          end
        end
        ST_LOCKED: begin
          if (fpu_gnt_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB_REQ; k++) begin
      if (rst) begin
        outst[k] <= '0;
      end else if (gnt_o[k] && !dec_vec[k]) begin
        outst[k] <= outst[k] + OW'(1);
      end else if (!gnt_o[k] && dec_vec[k]) begin
        outst[k] <= outst[k] - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      rflags_o <= '0;
      rID_o    <= '0;
    end else begin
      rvalid_o <= dec_vec;
      if (rsp_ok) begin
        rdata_o  <= fpu_rdata_i;
        rflags_o <= fpu_rflags_i;
        rID_o    <= fpu_rID_i[ID_WIDTH-1:0];
      end
    end
  end

`ifdef FPU_SHARE_PERF_EN
  logic conflict;

  assign conflict = ((state == ST_IDLE) && ((eligible & (eligible - NB_REQ'(1))) != '0)) ||
                    ((state == ST_LOCKED) && !fpu_gnt_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflicts_o <= '0;
    end else if (conflict && (perf_conflicts_o != '1)) begin
      perf_conflicts_o <= perf_conflicts_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb/tb_fpu_share_arbiter.sv - directed self-checking bench for fpu_share_arbiter
module tb_fpu_share_arbiter;

  localparam int NB_REQ = 4;
  localparam int IDW    = 9;
  localparam int NA     = 3;
  localparam int DW     = 32;
  localparam int OPW    = 6;
  localparam int FIW    = 15;
  localparam int FOW    = 5;
  localparam int MO     = 4;

  logic                               clk = 1'b0;
  logic                               rst;
  logic [NB_REQ-1:0]                  req_i;
  logic [NB_REQ-1:0]                  gnt_o;
  logic [NB_REQ-1:0][IDW-1:0]         ID_i;
  logic [NB_REQ-1:0][NA-1:0][DW-1:0]  operands_i;
  logic [NB_REQ-1:0][OPW-1:0]         op_i;
  logic [NB_REQ-1:0][FIW-1:0]         flags_i;
  logic [NB_REQ-1:0]                  rvalid_o;
  logic [DW-1:0]                      rdata_o;
  logic [FOW-1:0]                     rflags_o;
  logic [IDW-1:0]                     rID_o;
  logic                               fpu_req_o;
  logic                               fpu_gnt_i;
  logic [IDW+1:0]                     fpu_ID_o;
  logic [NA-1:0][DW-1:0]              fpu_operands_o;
  logic [OPW-1:0]                     fpu_op_o;
  logic [FIW-1:0]                     fpu_flags_o;
  logic                               fpu_rvalid_i;
  logic [DW-1:0]                      fpu_rdata_i;
  logic [FOW-1:0]                     fpu_rflags_i;
  logic [IDW+1:0]                     fpu_rID_i;
`ifdef FPU_SHARE_PERF_EN
  logic [31:0]                        perf_conflicts_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_share_arbiter #(
    .NB_REQ(NB_REQ), .ID_WIDTH(IDW), .NB_ARGS(NA), .DATA_WIDTH(DW),
    .OPCODE_WIDTH(OPW), .FLAGS_IN_WIDTH(FIW), .FLAGS_OUT_WIDTH(FOW), .MAX_OUTST(MO)
  ) dut (
`ifdef FPU_SHARE_PERF_EN
    .perf_conflicts_o (perf_conflicts_o),
`endif
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .ID_i           (ID_i),
    .operands_i     (operands_i),
    .op_i           (op_i),
    .flags_i        (flags_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .rflags_o       (rflags_o),
    .rID_o          (rID_o),
    .fpu_req_o      (fpu_req_o),
    .fpu_gnt_i      (fpu_gnt_i),
    .fpu_ID_o       (fpu_ID_o),
    .fpu_operands_o (fpu_operands_o),
    .fpu_op_o       (fpu_op_o),
    .fpu_flags_o    (fpu_flags_o),
    .fpu_rvalid_i   (fpu_rvalid_i),
    .fpu_rdata_i    (fpu_rdata_i),
    .fpu_rflags_i   (fpu_rflags_i),
    .fpu_rID_i      (fpu_rID_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic rsp(input logic [1:0] k, input logic [8:0] id, input logic [31:0] d,
                     input logic [4:0] f);
    fpu_rvalid_i = 1'b1;
    fpu_rID_i    = {k, id};
    fpu_rdata_i  = d;
    fpu_rflags_i = f;
    tick();
    fpu_rvalid_i = 1'b0;
    settle();
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] expg;

    rst          = 1'b1;
    req_i        = '0;
    fpu_gnt_i    = 1'b0;
    fpu_rvalid_i = 1'b0;
    fpu_rdata_i  = '0;
    fpu_rflags_i = '0;
    fpu_rID_i    = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      ID_i[k]    = 9'(16 + k);
      op_i[k]    = 6'(k + 1);
      flags_i[k] = 15'(k * 3);
      for (int a = 0; a < NA; a++) operands_i[k][a] = 32'(k * 4096 + a);
    end

    // reset state
    do_reset();
    settle();
    chk("rst_rvalid", rvalid_o, 4'b0000);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_rid", rID_o, 9'h0);
    chk("rst_fpu_req", fpu_req_o, 1'b0);
    chk("rst_gnt", gnt_o, 4'b0000);

    // full contention with an always-ready FPU rotates 0,1,2,3,0
    req_i     = 4'b1111;
    fpu_gnt_i = 1'b1;
    settle();
    chk("pay_id", fpu_ID_o[IDW-1:0], 9'h010);
    chk("pay_op", fpu_op_o, 6'd1);
    chk("pay_operand2", fpu_operands_o[2], 32'h2);
    for (int i = 0; i < 5; i++) begin
      expg = 4'(1 << order[i]);
      settle();
      chk("rr_gnt", gnt_o, expg);
      chk("rr_id_msb", fpu_ID_o[IDW+1:IDW], order[i]);
      tick();
    end

    // stall locks requester 0 even when the round-robin would now pick 1
    req_i     = '0;
    fpu_gnt_i = 1'b0;
    do_reset();
    req_i = 4'b0101;
    settle();
    chk("lock_req", fpu_req_o, 1'b1);
    chk("lock_nogrant", gnt_o, 4'b0000);
    tick();
    tick();
    tick();
    req_i = 4'b0110;
    settle();
    chk("lock_hold_msb", fpu_ID_o[IDW+1:IDW], 2'd0);
    req_i     = 4'b0111;
    fpu_gnt_i = 1'b1;
    settle();
    chk("lock_grant0", gnt_o, 4'b0001);
    tick();
    chk("after_lock_grant1", gnt_o, 4'b0010);

    // requester 2 saturates at MAX_OUTST and is masked until a response drains it
    req_i = '0;
    do_reset();
    req_i     = 4'b0100;
    fpu_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("sat_gnt2", gnt_o, 4'b0100);
      tick();
    end
    chk("sat_masked_req", fpu_req_o, 1'b0);
    chk("sat_masked_gnt", gnt_o, 4'b0000);
    req_i = 4'b1100;
    settle();
    chk("sat_gnt3", gnt_o, 4'b1000);
    tick();
    req_i     = 4'b0100;
    fpu_gnt_i = 1'b0;
    rsp(2'd2, 9'h0AA, 32'hDEADBEEF, 5'h1F);
    chk("sat_rsp_rvalid", rvalid_o, 4'b0100);
    chk("sat_rsp_rid", rID_o, 9'h0AA);
    fpu_gnt_i = 1'b1;
    settle();
    chk("sat_regrant2", gnt_o, 4'b0100);
    tick();

    // single-cycle registered response to requester 1
    req_i = '0;
    do_reset();
    req_i     = 4'b0010;
    fpu_gnt_i = 1'b1;
    tick();
    req_i     = '0;
    fpu_gnt_i = 1'b0;
    rsp(2'd1, 9'h05, 32'h3F800000, 5'h03);
    chk("rsp_rvalid", rvalid_o, 4'b0010);
    chk("rsp_rid", rID_o, 9'h05);
    chk("rsp_rdata", rdata_o, 32'h3F800000);
    chk("rsp_rflags", rflags_o, 5'h03);
    tick();
    chk("rsp_one_cycle", rvalid_o, 4'b0000);
    rsp(2'd3, 9'h033, 32'h12345678, 5'h00);
    chk("rsp_drop_idle", rvalid_o, 4'b0000);

    // simultaneous grant and response keep outst[1] at 1: exactly one more response is accepted
    req_i     = 4'b0010;
    fpu_gnt_i = 1'b1;
    tick();
    fpu_rvalid_i = 1'b1;
    fpu_rID_i    = {2'd1, 9'h07};
    fpu_rdata_i  = 32'h40000000;
    settle();
    chk("both_gnt1", gnt_o, 4'b0010);
    tick();
    fpu_rvalid_i = 1'b0;
    req_i        = '0;
    fpu_gnt_i    = 1'b0;
    settle();
    chk("both_rvalid", rvalid_o, 4'b0010);
    rsp(2'd1, 9'h08, 32'h1, 5'h0);
    chk("both_last_rsp", rvalid_o, 4'b0010);
    rsp(2'd1, 9'h09, 32'h2, 5'h0);
    chk("both_extra_dropped", rvalid_o, 4'b0000);

    // reset while locked returns to IDLE and drops stale responses
    req_i = 4'b0001;
    tick();
    req_i = '0;
    settle();
    chk("locked_after_deassert", fpu_req_o, 1'b1);
    do_reset();
    settle();
    chk("rst_lock_req", fpu_req_o, 1'b0);
    chk("rst_lock_rdata", rdata_o, 32'h0);
    chk("rst_lock_rid", rID_o, 9'h0);
    rsp(2'd0, 9'h011, 32'hCAFEF00D, 5'h02);
    chk("rst_stale_drop", rvalid_o, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
